// File: rtl/clk_div_tuner.sv
// Adaptive clock-divide tuner: walks the divide ratio down from DIV_MAX until the
// comparator reports an error, backs off one step and locks; also paces clk_en.
module clk_div_tuner #(
    parameter int DIV_W    = 8,
    parameter int DIV_MAX  = 16,
    parameter int DIV_MIN  = 1,
    parameter int PASS_CNT = 8,
    parameter int SETTLE   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             smp_valid,
    input  logic             err_flag,
    output logic [DIV_W-1:0] clk_div,
    output logic             clk_en,
    output logic             busy,
    output logic             done,
    output logic             fail
);

    localparam int PW = $clog2(PASS_CNT + 1);
    localparam int SW = $clog2(SETTLE + 1);

    localparam logic [DIV_W-1:0] RATIO_MAX   = DIV_W'(DIV_MAX);
    localparam logic [DIV_W-1:0] RATIO_MIN   = DIV_W'(DIV_MIN);
    localparam logic [PW-1:0]    PASS_LAST   = PW'(PASS_CNT - 1);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_PROBE,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] div_cnt, cnt_nxt;
    logic [PW-1:0]    pass_cnt, pass_nxt;
    logic [SW-1:0]    settle_cnt, settle_nxt;
    logic             div_write;
    logic             en_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            clk_div    <= RATIO_MAX;
            div_cnt    <= '0;
            pass_cnt   <= '0;
            settle_cnt <= '0;
            clk_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_nxt;
            clk_div    <= div_nxt;
            div_cnt    <= cnt_nxt;
            pass_cnt   <= pass_nxt;
            settle_cnt <= settle_nxt;
            clk_en     <= en_nxt;
            busy       <= (state_nxt == ST_SETTLE) || (state_nxt == ST_PROBE);
            done       <= (state_nxt == ST_LOCKED) || (state_nxt == ST_FAIL);
            fail       <= (state_nxt == ST_FAIL);
        end
    end

    always_comb begin
        state_nxt  = state;
        div_nxt    = clk_div;
        pass_nxt   = pass_cnt;
        settle_nxt = settle_cnt;
        div_write  = 1'b0;

        case (state)
            ST_IDLE, ST_LOCKED, ST_FAIL: begin
                if (start) begin
                    state_nxt  = ST_SETTLE;
                    div_nxt    = RATIO_MAX;
                    div_write  = 1'b1;
                    pass_nxt   = '0;
                    settle_nxt = '0;
                end
            end
            ST_SETTLE: begin
                if (smp_valid) begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nxt  = ST_PROBE;
                        pass_nxt   = '0;
                        settle_nxt = '0;
                    end else begin
                        settle_nxt = settle_cnt + 1'b1;
                    end
                end
            end
            ST_PROBE: begin
                if (smp_valid) begin
                    if (err_flag) begin
                        // An error at the slowest ratio leaves nowhere to back off to
                        if (clk_div == RATIO_MAX) begin
                            state_nxt = ST_FAIL;
                        end else begin
                            div_nxt   = clk_div + 1'b1;
                            div_write = 1'b1;
                            state_nxt = ST_LOCKED;
                        end
                    end else if (pass_cnt == PASS_LAST) begin
                        pass_nxt = '0;
                        if (clk_div == RATIO_MIN) begin
                            state_nxt = ST_LOCKED;
                        end else begin
                            div_nxt    = clk_div - 1'b1;
                            div_write  = 1'b1;
                            state_nxt  = ST_SETTLE;
                            settle_nxt = '0;
                        end
                    end else begin
                        pass_nxt = pass_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A ratio write restarts the strobe period; clk_en is registered from the next count
    always_comb begin
        cnt_nxt = div_cnt + 1'b1;
        if (div_write || (div_cnt == clk_div - 1'b1)) begin
            cnt_nxt = '0;
        end
        en_nxt = (cnt_nxt == div_nxt - 1'b1);
    end

endmodule

// File: tb/tb_clk_div_tuner.sv
// Self-checking bench for clk_div_tuner: vector table, directed corner sequences
// and randomized stimulus against a behavioural model of the tuning procedure.
module tb_clk_div_tuner;

    localparam int DIV_W    = 8;
    localparam int DIV_MAX  = 16;
    localparam int DIV_MIN  = 1;
    localparam int PASS_CNT = 8;
    localparam int SETTLE   = 4;

    localparam int M_IDLE   = 0;
    localparam int M_SETTLE = 1;
    localparam int M_PROBE  = 2;
    localparam int M_LOCKED = 3;
    localparam int M_FAIL   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             smp_valid = 1'b0;
    logic             err_flag = 1'b0;
    logic [DIV_W-1:0] clk_div;
    logic             clk_en;
    logic             busy;
    logic             done;
    logic             fail;

    int checks = 0;
    int errors = 0;

    // Model: tuning mode, ratio, sample counts and cycles elapsed since the ratio was written
    int m_mode   = M_IDLE;
    int m_div    = DIV_MAX;
    int m_pass   = 0;
    int m_settle = 0;
    int m_since  = 0;

    typedef struct {
        logic r, s, v, e;
        int   div;
        logic en, bsy, dn, fl;
    } vec_t;

    vec_t vecs[10];

    clk_div_tuner #(
        .DIV_W(DIV_W), .DIV_MAX(DIV_MAX), .DIV_MIN(DIV_MIN),
        .PASS_CNT(PASS_CNT), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
        .err_flag(err_flag), .clk_div(clk_div), .clk_en(clk_en),
        .busy(busy), .done(done), .fail(fail)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r, input logic s, input logic v, input logic e);
        bit wrote = 0;
        if (r) begin
            m_mode = M_IDLE; m_div = DIV_MAX; m_pass = 0; m_settle = 0; m_since = 0;
            return;
        end
        case (m_mode)
            M_SETTLE: if (v) begin
                m_settle++;
                if (m_settle == SETTLE) begin
                    m_mode = M_PROBE; m_pass = 0; m_settle = 0;
                end
            end
            M_PROBE: if (v) begin
                if (e) begin
                    if (m_div == DIV_MAX) m_mode = M_FAIL;
                    else begin m_div++; wrote = 1; m_mode = M_LOCKED; end
                end else begin
                    m_pass++;
                    if (m_pass == PASS_CNT) begin
                        m_pass = 0;
                        if (m_div == DIV_MIN) m_mode = M_LOCKED;
                        else begin m_div--; wrote = 1; m_mode = M_SETTLE; m_settle = 0; end
                    end
                end
            end
            default: if (s) begin
                m_mode = M_SETTLE; m_div = DIV_MAX; wrote = 1; m_pass = 0; m_settle = 0;
            end
        endcase
        m_since = wrote ? 0 : (m_since + 1) % m_div;
    endtask

    task automatic check_field(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_output();
        check_field("model clk_div", int'(clk_div), m_div);
        check_field("model clk_en", int'(clk_en), int'(m_since == m_div - 1));
        check_field("model busy", int'(busy), int'(m_mode == M_SETTLE || m_mode == M_PROBE));
        check_field("model done", int'(done), int'(m_mode == M_LOCKED || m_mode == M_FAIL));
        check_field("model fail", int'(fail), int'(m_mode == M_FAIL));
    endtask

    task automatic apply_stimulus(input logic r, input logic s, input logic v, input logic e);
        rst = r; start = s; smp_valid = v; err_flag = e;
        @(posedge clk);
        model_step(r, s, v, e);
        #1;
        check_output();
    endtask

    task automatic run_until(input int div, input int mode, input string name);
        int n = 0;
        while (!(m_div == div && m_mode == mode) && n < 400) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        if (n >= 400) check_field({name, " timeout"}, n, 0);
    endtask

    initial begin
        // inputs r s v e, then expected clk_div clk_en busy done fail
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 16, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, 1'b0};

        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].r, vecs[i].s, vecs[i].v, vecs[i].e);
            check_field($sformatf("vec%0d clk_div", i), int'(clk_div), vecs[i].div);
            check_field($sformatf("vec%0d clk_en", i), int'(clk_en), int'(vecs[i].en));
            check_field($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].bsy));
            check_field($sformatf("vec%0d done", i), int'(done), int'(vecs[i].dn));
            check_field($sformatf("vec%0d fail", i), int'(fail), int'(vecs[i].fl));
        end

        // Idle strobe: the cycle after the reset edge is cycle 1, pulses land on 16, 32, 48
        for (int k = 1; k <= 48; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
            check_field("idle strobe", int'(clk_en), int'((k + 1) % 16 == 0));
        end
        check_field("idle clk_div", int'(clk_div), 16);

        // Clean samples every cycle walk the ratio all the way down to DIV_MIN
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 192; n++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
            if (n == 12) check_field("walk first step", int'(clk_div), 15);
            if (n == 191) check_field("walk done early", int'(done), 0);
        end
        check_field("walk clk_div", int'(clk_div), 1);
        check_field("walk done", int'(done), 1);
        check_field("walk fail", int'(fail), 0);
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
            check_field("div1 strobe", int'(clk_en), 1);
        end

        // Settle-phase errors are ignored, then 8 passes step 16 -> 15
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check_field("settle err clk_div", int'(clk_div), 15);
        check_field("settle err busy", int'(busy), 1);

        // First probe error at ratio 10 backs off to 11 and locks
        run_until(10, M_PROBE, "reach div10");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
        check_field("backoff clk_div", int'(clk_div), 11);
        check_field("backoff done", int'(done), 1);
        check_field("backoff busy", int'(busy), 0);
        check_field("backoff fail", int'(fail), 0);
        check_field("backoff en c1", int'(clk_en), 0);
        for (int k = 2; k <= 11; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
            check_field($sformatf("backoff en c%0d", k), int'(clk_en), int'(k == 11));
        end

        // Reset mid-probe, then a start whose same-cycle sample must not count
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        run_until(7, M_PROBE, "reach div7");
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
        check_field("midrst clk_div", int'(clk_div), 16);
        check_field("midrst busy", int'(busy), 0);
        check_field("midrst clk_en", int'(clk_en), 0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
        check_field("discard still settling", int'(fail), 0);
        check_field("discard busy", int'(busy), 1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
        check_field("discard then fail", int'(fail), 1);

        // Randomized traffic; each tuning run picks a noisy or quiet error rate
        begin
            int err_div = 64;
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 4000; c++) begin
                logic r, s, v, e;
                r = ($urandom_range(0, 299) == 0);
                s = ($urandom_range(0, 39) == 0);
                v = ($urandom_range(0, 9) < 6);
                e = ($urandom_range(0, err_div - 1) == 0);
                if (s) err_div = ($urandom_range(0, 2) == 0) ? 8 : 96;
                apply_stimulus(r, s, v, e);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_tuner.md
# clk_div_tuner

Adaptive divider controller that sits directly downstream of the golden-data comparator and upstream of the clock-enable consumers (random data generator and checker). It consumes per-sample pass/fail results, walks the clock divide ratio down from the slowest setting until an error appears, backs off one step and locks. It also generates the divided clock-enable strobe that paces the data generator and checker.

## Interface
- `DIV_W`, 8: width of divide ratio.
- `DIV_MAX`, 16: starting (slowest) ratio; must be ≤ 2^DIV_W−1.
- `DIV_MIN`, 1: fastest allowed ratio; 1 ≤ DIV_MIN < DIV_MAX.
- `PASS_CNT`, 8: consecutive error-free counted samples required before stepping down.
- `SETTLE`, 4: valid samples discarded after every ratio change.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin tuning.
- `smp_valid`  in  1  comparator result valid this cycle.
- `err_flag`  in  1  comparator mismatch; qualified by `smp_valid`.
- `clk_div`  out  DIV_W  current divide ratio.
- `clk_en`  out  1  one-cycle strobe every `clk_div` cycles.
- `busy`  out  1  high in SETTLE and PROBE.
- `done`  out  1  high in LOCKED and FAIL.
- `fail`  out  1  high in FAIL only.

## Operation
- Reset: `clk_div`=DIV_MAX, `clk_en`=0, `busy`=0, `done`=0, `fail`=0, state IDLE, divide counter=0, pass counter=0, settle counter=0.
- Strobe generator: counter `div_cnt` counts 0..clk_div−1. `clk_en`=1 in the cycle where `div_cnt`==clk_div−1, and the counter wraps to 0. With `clk_div`=1, `clk_en` is high every cycle. It runs in all states.
- Any write to `clk_div` clears `div_cnt` to 0 in the same cycle. The next `clk_en` therefore follows exactly new-`clk_div` cycles later.
- States:
  - IDLE: on `start` → SETTLE, `clk_div`=DIV_MAX, counters cleared. `smp_valid` is ignored.
  - SETTLE: each `smp_valid` increments the settle counter; `err_flag` is ignored. On the SETTLE-th valid sample → PROBE, pass counter=0.
  - PROBE, valid sample with `err_flag`=1:
    - If `clk_div`==DIV_MAX → FAIL, `clk_div` unchanged.
    - Otherwise `clk_div`+1 → LOCKED.
  - PROBE, valid sample with `err_flag`=0: pass counter increments. On the PASS_CNT-th pass:
    - If `clk_div`==DIV_MIN → LOCKED, `clk_div` unchanged.
    - Otherwise `clk_div`−1 → SETTLE, settle counter=0.
  - LOCKED / FAIL: hold `clk_div`. `smp_valid` is ignored. `start` restarts exactly as from IDLE: `clk_div`=DIV_MAX → SETTLE.
- `start` in SETTLE or PROBE is ignored.
- Arithmetic: ratio ±1 never leaves [DIV_MIN, DIV_MAX]; the bound checks above guarantee this. Counters are sized with $clog2 of their limits and never wrap.

## Timing
- All outputs are registered. State and `clk_div` update on the edge after the qualifying input cycle, so there is 1-cycle latency from sample to new `clk_div` / `done`.
- `start` and `smp_valid` in the same IDLE/LOCKED/FAIL cycle: `start` is taken and the sample is discarded. It does not count toward SETTLE.
- `busy`, `done` and `fail` change in the same cycle as the state.
- `rst` mid-operation returns to the reset values on the next edge, regardless of state. `clk_en` is 0 in the cycle following reset.
- `smp_valid` may be asserted on consecutive cycles. Each valid cycle is one sample.

## Test plan
- Reset release with no stimulus: all outputs at reset values; `clk_en` pulses on cycles 16, 32, 48… after reset deasserts; `clk_div` stays 16.
- `start`, then `smp_valid`=1 / `err_flag`=0 every cycle: `clk_div` steps 16→15→…→1, one step per 12 samples. After 192 samples `done`=1, `fail`=0, `clk_div`=1, and `clk_en` is high every cycle.
- Same as above, but the first PROBE error occurs when `clk_div`=10: next cycle `clk_div`=11, `done`=1, `busy`=0, `fail`=0. The following `clk_en` arrives 11 cycles after the change.
- `err_flag`=1 on all 4 SETTLE samples, then 8 passes: errors are ignored and `clk_div` steps 16→15.
- Error on the first PROBE sample at DIV_MAX: `fail`=1, `done`=1, `clk_div`=16. A later `start` clears `fail` and re-enters SETTLE.
- `rst` asserted while `clk_div`=7 in PROBE: next cycle `clk_div`=16 and `busy`=0. A subsequent `start` with `smp_valid` in the same cycle discards that sample.
